// File: rtl/switch_count_to_digits.sv
// Two debounced pushbuttons step a two-digit count (decimal 00-99 or hex 00-FF)
// up or down; the digits feed a pair of 7-segment encoders.
module switch_count_to_digits #(
  parameter int DEBOUNCE_LIMIT = 250000,
  parameter int BCD_MODE       = 1
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Switch_Inc,
  input  logic       i_Switch_Dec,
  output logic [3:0] o_Ones_Num,
  output logic [3:0] o_Tens_Num,
  output logic       o_Count_Pulse
);

  // The counter only ever reaches DEBOUNCE_LIMIT-1 before it clears.
  localparam int CW = (DEBOUNCE_LIMIT > 2) ? $clog2(DEBOUNCE_LIMIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_LIMIT - 1);

  // Index 0 is the increment switch, index 1 the decrement switch.
  logic [1:0]    raw;
  logic [1:0]    meta;
  logic [1:0]    sync;
  logic [1:0]    stable;
  logic [1:0]    press;
  logic [CW-1:0] deb_cnt [2];
  logic [7:0]    count;
  logic [7:0]    count_up;
  logic [7:0]    count_down;
  logic          count_pulse;

  assign raw = {i_Switch_Dec, i_Switch_Inc};

  function automatic logic [7:0] step_up(input logic [7:0] v);
    logic [7:0] r;
    r = v;
    if (BCD_MODE != 0) begin
      if (v[3:0] == 4'd9) begin
        r[3:0] = 4'd0;
        r[7:4] = (v[7:4] == 4'd9) ? 4'd0 : v[7:4] + 4'd1;
      end else begin
        r[3:0] = v[3:0] + 4'd1;
      end
    end else begin
      r = v + 8'd1;
    end
    return r;
  endfunction

  function automatic logic [7:0] step_down(input logic [7:0] v);
    logic [7:0] r;
    r = v;
    if (BCD_MODE != 0) begin
      if (v[3:0] == 4'd0) begin
        r[3:0] = 4'd9;
        r[7:4] = (v[7:4] == 4'd0) ? 4'd9 : v[7:4] - 4'd1;
      end else begin
        r[3:0] = v[3:0] - 4'd1;
      end
    end else begin
      r = v - 8'd1;
    end
    return r;
  endfunction

  // Synchronise, then debounce; a press strobe fires only on a 0->1 accept.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      meta   <= 2'b00;
      sync   <= 2'b00;
      stable <= 2'b00;
      press  <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        deb_cnt[i] <= '0;
      end
    end else begin
      meta <= raw;
      sync <= meta;
      for (int i = 0; i < 2; i++) begin
        press[i] <= 1'b0;
        if (sync[i] != stable[i]) begin
          if (deb_cnt[i] == CNT_LAST) begin
            stable[i]  <= ~stable[i];
            deb_cnt[i] <= '0;
            press[i]   <= ~stable[i];
          end else begin
            deb_cnt[i] <= deb_cnt[i] + 1'b1;
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  always_comb begin
    count_up   = step_up(count);
    count_down = step_down(count);
  end

  // Simultaneous presses cancel: no change and no strobe.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      count       <= 8'h00;
      count_pulse <= 1'b0;
    end else begin
      count_pulse <= press[0] ^ press[1];
      case (press)
        2'b01:   count <= count_up;
        2'b10:   count <= count_down;
        default: count <= count;
      endcase
    end
  end

  assign o_Ones_Num    = count[3:0];
  assign o_Tens_Num    = count[7:4];
  assign o_Count_Pulse = count_pulse;

endmodule

// File: tb/tb_switch_count_to_digits.sv
// Directed bench: one decimal and one hex instance (DEBOUNCE_LIMIT=4) driven
// from a vector table plus hand-written timing, wrap and reset sequences.
module tb_switch_count_to_digits;

  logic       clk = 1'b0;
  logic       rst;
  logic       inc_b, dec_b, inc_h, dec_h;
  logic [3:0] ones_b, tens_b, ones_h, tens_h;
  logic       pulse_b, pulse_h;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  switch_count_to_digits #(.DEBOUNCE_LIMIT(4), .BCD_MODE(1)) u_bcd (
    .i_Clk(clk), .i_Rst(rst), .i_Switch_Inc(inc_b), .i_Switch_Dec(dec_b),
    .o_Ones_Num(ones_b), .o_Tens_Num(tens_b), .o_Count_Pulse(pulse_b)
  );

  switch_count_to_digits #(.DEBOUNCE_LIMIT(4), .BCD_MODE(0)) u_hex (
    .i_Clk(clk), .i_Rst(rst), .i_Switch_Inc(inc_h), .i_Switch_Dec(dec_h),
    .o_Ones_Num(ones_h), .o_Tens_Num(tens_h), .o_Count_Pulse(pulse_h)
  );

  typedef struct {
    string      name;
    logic       sel_hex;
    logic       inc;
    logic       dec;
    logic [7:0] exp_digits;
    int         exp_pulses;
  } vec_t;

  vec_t vecs[12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Hold the given switches long enough to debounce, then release them.
  task automatic do_press(input logic bi, input logic bd, input logic hi, input logic hd,
                          output int pb, output int ph);
    pb = 0;
    ph = 0;
    inc_b = bi; dec_b = bd; inc_h = hi; dec_h = hd;
    repeat (12) begin
      tick();
      pb += int'(pulse_b);
      ph += int'(pulse_h);
    end
    inc_b = 0; dec_b = 0; inc_h = 0; dec_h = 0;
    repeat (12) begin
      tick();
      pb += int'(pulse_b);
      ph += int'(pulse_h);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  initial begin
    int pb, ph, pulses, exp_b;
    logic [3:0] et, eo;

    vecs[0]  = '{"bcd_dec_01_00",  1'b0, 1'b0, 1'b1, 8'h00, 1};
    vecs[1]  = '{"bcd_dec_wrap",   1'b0, 1'b0, 1'b1, 8'h99, 1};
    vecs[2]  = '{"bcd_inc_wrap",   1'b0, 1'b1, 1'b0, 8'h00, 1};
    vecs[3]  = '{"bcd_inc_00_01",  1'b0, 1'b1, 1'b0, 8'h01, 1};
    vecs[4]  = '{"bcd_both",       1'b0, 1'b1, 1'b1, 8'h01, 0};
    vecs[5]  = '{"hex_inc_00_01",  1'b1, 1'b1, 1'b0, 8'h01, 1};
    vecs[6]  = '{"hex_dec_01_00",  1'b1, 1'b0, 1'b1, 8'h00, 1};
    vecs[7]  = '{"hex_dec_wrap",   1'b1, 1'b0, 1'b1, 8'hFF, 1};
    vecs[8]  = '{"hex_dec_ff_fe",  1'b1, 1'b0, 1'b1, 8'hFE, 1};
    vecs[9]  = '{"hex_inc_fe_ff",  1'b1, 1'b1, 1'b0, 8'hFF, 1};
    vecs[10] = '{"hex_inc_wrap",   1'b1, 1'b1, 1'b0, 8'h00, 1};
    vecs[11] = '{"hex_both",       1'b1, 1'b1, 1'b1, 8'h00, 0};

    rst = 1'b1;
    inc_b = 0; dec_b = 0; inc_h = 0; dec_h = 0;
    repeat (3) tick();
    rst = 1'b0;
    check("reset_bcd", {tens_b, ones_b, pulse_b}, 9'h000);
    check("reset_hex", {tens_h, ones_h, pulse_h}, 9'h000);

    // First press: edge 1 samples, digits must change on edge 7 only.
    inc_b = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check($sformatf("latency_edge%0d", k), {tens_b, ones_b, pulse_b}, 9'h000);
    end
    tick();
    check("first_count", {tens_b, ones_b, pulse_b}, {8'h01, 1'b1});
    tick();
    check("pulse_one_clk", pulse_b, 0);
    pulses = 0;
    repeat (100) begin
      tick();
      pulses += int'(pulse_b);
    end
    check("no_repeat_pulses", pulses, 0);
    check("no_repeat_digits", {tens_b, ones_b}, 8'h01);
    inc_b = 1'b0;
    repeat (12) tick();

    // Three-clock glitch is shorter than the debounce limit.
    inc_b = 1'b1;
    repeat (3) tick();
    inc_b = 1'b0;
    pulses = 0;
    repeat (15) begin
      tick();
      pulses += int'(pulse_b);
    end
    check("glitch_pulses", pulses, 0);
    check("glitch_digits", {tens_b, ones_b}, 8'h01);

    for (int i = 0; i < 12; i++) begin
      if (vecs[i].sel_hex) begin
        do_press(1'b0, 1'b0, vecs[i].inc, vecs[i].dec, pb, ph);
        check({vecs[i].name, "_digits"}, {tens_h, ones_h}, vecs[i].exp_digits);
        check({vecs[i].name, "_pulses"}, ph, vecs[i].exp_pulses);
      end else begin
        do_press(vecs[i].inc, vecs[i].dec, 1'b0, 1'b0, pb, ph);
        check({vecs[i].name, "_digits"}, {tens_b, ones_b}, vecs[i].exp_digits);
        check({vecs[i].name, "_pulses"}, pb, vecs[i].exp_pulses);
      end
    end

    // Long increment runs on both instances; the decimal one is tracked by a model.
    do_reset();
    exp_b = 0;
    for (int i = 0; i < 16; i++) begin
      do_press(1'b1, 1'b0, 1'b1, 1'b0, pb, ph);
      exp_b++;
      if (i == 14) check("hex_15_inc", {tens_h, ones_h}, 8'h0F);
    end
    check("hex_16_inc", {tens_h, ones_h}, 8'h10);
    check("bcd_16_inc", {tens_b, ones_b}, 8'h16);
    while (exp_b < 99) begin
      do_press(1'b1, 1'b0, 1'b0, 1'b0, pb, ph);
      exp_b++;
      et = 4'(exp_b / 10);
      eo = 4'(exp_b % 10);
      check($sformatf("bcd_run_%0d", exp_b), {tens_b, ones_b, 1'(pb)}, {et, eo, 1'b1});
    end
    do_press(1'b1, 1'b0, 1'b0, 1'b0, pb, ph);
    check("bcd_99_wrap_up", {tens_b, ones_b}, 8'h00);
    do_press(1'b0, 1'b1, 1'b0, 1'b0, pb, ph);
    check("bcd_00_wrap_down", {tens_b, ones_b}, 8'h99);

    // Reset in the middle of a debounce: the held switch is re-debounced.
    do_reset();
    inc_b = 1'b1;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_reset_clear", {tens_b, ones_b, pulse_b}, 9'h000);
    for (int k = 1; k <= 6; k++) begin
      tick();
      check($sformatf("post_reset_edge%0d", k), {tens_b, ones_b, pulse_b}, 9'h000);
    end
    tick();
    check("post_reset_count", {tens_b, ones_b, pulse_b}, {8'h01, 1'b1});
    inc_b = 1'b0;
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
